// File: rtl/chesssoc_onchip_ram_pipelined_if.sv
// Avalon-MM slave bus bundle for the pipelined on-chip RAM.
// The master drives the request side; the slave returns data, valid and stall.
interface chesssoc_onchip_ram_pipelined_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic [BE_WIDTH-1:0]   byteenable;
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;
  logic                  waitrequest;

  modport master (
    output address, byteenable, chipselect, read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect, read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/chesssoc_onchip_ram_pipelined.sv
// Parametrised Avalon-MM on-chip RAM: 1/2-cycle registered reads, byte-lane writes, clear sequencer.
// Define CHESSSOC_ONCHIP_RAM_PORTB_EN to add a registered read-only port B for the VGA renderer.
module chesssoc_onchip_ram_pipelined #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 6,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input  logic clk,
  input  logic reset,
  chesssoc_onchip_ram_pipelined_if.slave bus,
  input  logic clken,
  input  logic freeze,
  input  logic reset_req,
  input  logic clear,
  output logic busy
`ifdef CHESSSOC_ONCHIP_RAM_PORTB_EN
  ,
  input  logic [ADDR_WIDTH-1:0] b_address,
  output logic [DATA_WIDTH-1:0] b_readdata
`endif
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 2 ** ADDR_WIDTH;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  clocken0;
  logic                  stall;
  logic                  accept_rd, accept_wr;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [BE_WIDTH-1:0]   wr_be;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign clocken0  = clken & ~reset_req;
  assign stall     = (state_q == S_CLEAR) | ~clocken0 | freeze;
  assign accept_wr = bus.chipselect & bus.write & ~stall;
  // A simultaneous read+write is a write only, so it never produces readdatavalid.
  assign accept_rd = bus.chipselect & bus.read & ~bus.write & ~stall;
  assign busy      = (state_q == S_CLEAR);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
    end else if (clocken0) begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d    = S_CLEAR;
          clr_addr_d = '0;
        end
      end
      S_CLEAR: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (&clr_addr_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The clear sequencer and the bus share the single write port; CLEAR stalls the bus.
  always_comb begin
    wr_en   = accept_wr;
    wr_addr = bus.address;
    wr_data = bus.writedata;
    wr_be   = bus.byteenable;
    if (state_q == S_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr_q;
      wr_data = INIT_VALUE;
      wr_be   = '1;
    end
  end

  // NOTE: the array has no reset; the clear sequencer initialises it after reset.
  always_ff @(posedge clk) begin
    if (clocken0 && wr_en) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_word = mem[bus.address];

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s1_data;
      logic                  s1_valid;

      always_ff @(posedge clk) begin
        if (reset) begin
          s1_data   <= '0;
          s1_valid  <= 1'b0;
          out_data  <= '0;
          out_valid <= 1'b0;
        end else if (clocken0) begin
          s1_valid  <= accept_rd;
          if (accept_rd) s1_data <= rd_word;
          out_valid <= s1_valid;
          if (s1_valid) out_data <= s1_data;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (reset) begin
          out_data  <= '0;
          out_valid <= 1'b0;
        end else if (clocken0) begin
          out_valid <= accept_rd;
          if (accept_rd) out_data <= rd_word;
        end
      end
    end
  endgenerate

  // A held valid is masked while stalled and re-presents once clocken0 returns.
  assign bus.readdata      = out_data;
  assign bus.readdatavalid = out_valid & clocken0;
  assign bus.waitrequest   = stall;

`ifdef CHESSSOC_ONCHIP_RAM_PORTB_EN
  always_ff @(posedge clk) begin
    if (reset)         b_readdata <= '0;
    else if (clocken0) b_readdata <= mem[b_address];
  end
`endif
endmodule
